// File: rtl/avalon_seg_writer_de1soc_pkg.sv
// Shared types and constants for the DE1-SoC seven-segment Avalon writer.
package seg_writer_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE} state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [3:0] BYTEEN_DIGIT = 4'b0001;

    // Largest value that fits in n decimal digits; used as the clamp limit.
    function automatic longint unsigned pow10_max(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/avalon_seg_writer_de1soc_if.sv
// Value handshake plus Avalon-MM write master signals of the segment writer.
interface avalon_seg_writer_de1soc_if #(
    parameter int DATA_W = 20
);
    logic [DATA_W-1:0] value_i;
    logic              valid_i;
    logic              ready_o;
    logic              done_o;
    logic              overflow_o;
    logic [2:0]        avm_address_o;
    logic [3:0]        avm_byteenable_o;
    logic              avm_write_o;
    logic [31:0]       avm_writedata_o;
    logic              avm_waitrequest_i;

    modport master (
        input  value_i, valid_i, avm_waitrequest_i,
        output ready_o, done_o, overflow_o,
        output avm_address_o, avm_byteenable_o, avm_write_o, avm_writedata_o
    );

    modport slave (
        output value_i, valid_i, avm_waitrequest_i,
        input  ready_o, done_o, overflow_o,
        input  avm_address_o, avm_byteenable_o, avm_write_o, avm_writedata_o
    );
endinterface

// File: rtl/avalon_seg_writer_de1soc_bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle, DATA_W steps per value.
module bin_to_bcd_seq
    import seg_writer_pkg::*;
#(
    parameter int DATA_W      = 20,
    parameter int NUM_SEGMENT = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [DATA_W-1:0]                 value_i,
    output logic                              busy_o,
    output logic                              done_o,
    output bcd_digit_t [NUM_SEGMENT-1:0]      bcd_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = NUM_SEGMENT * 4;

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              last;

    // High during the final shift; the result is in bcd_q from the next cycle.
    assign last = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_SEGMENT; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            bin_d  = value_i;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bin_d  = bin_q << 1;
            bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
            cnt_d  = cnt_q + 1'b1;
            busy_d = !last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = last;
    assign bcd_o  = bcd_q;
endmodule

// File: rtl/avalon_seg_writer_de1soc.sv
// Converts a binary value to BCD and writes only the changed digits to the
// seven-segment slave, one word per digit.
module avalon_seg_writer_de1soc
    import seg_writer_pkg::*;
#(
    parameter int NUM_SEGMENT = 6,
    parameter int DATA_W      = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    avalon_seg_writer_de1soc_if.master bus
);
    localparam int              IDX_W       = $clog2(NUM_SEGMENT + 1);
    localparam longint unsigned CLAMP_MAX   = pow10_max(NUM_SEGMENT);
    localparam logic [63:0]     CLAMP_MAX_V = 64'(CLAMP_MAX);

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              nxt_q, nxt_d;
    bcd_digit_t [NUM_SEGMENT-1:0]  shadow_q, shadow_d;
    logic                          shadow_valid_q, shadow_valid_d;
    logic                          clamp_hit_q, clamp_hit_d;
    logic                          ready_q, ready_d;
    logic                          done_q, done_d;
    logic                          overflow_q, overflow_d;
    logic                          avm_write_q, avm_write_d;
    logic [2:0]                    avm_address_q, avm_address_d;
    logic [3:0]                    avm_byteenable_q, avm_byteenable_d;
    logic [31:0]                   avm_writedata_q, avm_writedata_d;

    logic                          accept, clamp, conv_busy, conv_done;
    logic [DATA_W-1:0]             conv_value;
    bcd_digit_t [NUM_SEGMENT-1:0]  digits;
    bcd_digit_t                    sel_digit, sel_shadow;

    assign accept     = (state_q == IDLE) && bus.valid_i && !conv_busy;
    assign clamp      = 64'(bus.value_i) > CLAMP_MAX_V;
    assign conv_value = clamp ? CLAMP_MAX_V[DATA_W-1:0] : bus.value_i;

    bin_to_bcd_seq #(
        .DATA_W      (DATA_W),
        .NUM_SEGMENT (NUM_SEGMENT)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept),
        .value_i (conv_value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (digits)
    );

    always_comb begin
        state_d          = state_q;
        nxt_d            = nxt_q;
        shadow_d         = shadow_q;
        shadow_valid_d   = shadow_valid_q;
        clamp_hit_d      = accept && clamp;
        overflow_d       = clamp_hit_q;
        done_d           = 1'b0;
        avm_write_d      = 1'b0;
        avm_address_d    = '0;
        avm_byteenable_d = '0;
        avm_writedata_d  = '0;
        sel_digit        = '0;
        sel_shadow       = '0;
        for (int k = 0; k < NUM_SEGMENT; k++) begin
            if (k == int'(nxt_q)) begin
                sel_digit  = digits[k];
                sel_shadow = shadow_q[k];
            end
        end

        case (state_q)
            IDLE: if (accept) state_d = CONVERT;
            CONVERT: begin
                if (conv_done) begin
                    state_d = WRITE;
                    nxt_d   = '0;
                end
            end
            WRITE: begin
                if (avm_write_q && bus.avm_waitrequest_i) begin
                    avm_write_d      = 1'b1;
                    avm_address_d    = avm_address_q;
                    avm_byteenable_d = avm_byteenable_q;
                    avm_writedata_d  = avm_writedata_q;
                end else begin
                    // The write on the bus (if any) completes here; present the next digit.
                    if (avm_write_q) begin
                        for (int k = 0; k < NUM_SEGMENT; k++) begin
                            if (k == int'(avm_address_q)) shadow_d[k] = avm_writedata_q[3:0];
                        end
                    end
                    if (nxt_q == IDX_W'(NUM_SEGMENT)) begin
                        state_d        = IDLE;
                        shadow_valid_d = 1'b1;
                        done_d         = 1'b1;
                    end else begin
                        if (!shadow_valid_q || sel_digit != sel_shadow) begin
                            avm_write_d      = 1'b1;
                            avm_address_d    = 3'(nxt_q);
                            avm_byteenable_d = BYTEEN_DIGIT;
                            avm_writedata_d  = {28'b0, sel_digit};
                        end
                        nxt_d = nxt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            nxt_q            <= '0;
            shadow_q         <= '0;
            shadow_valid_q   <= 1'b0;
            clamp_hit_q      <= 1'b0;
            ready_q          <= 1'b1;
            done_q           <= 1'b0;
            overflow_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_byteenable_q <= '0;
            avm_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            nxt_q            <= nxt_d;
            shadow_q         <= shadow_d;
            shadow_valid_q   <= shadow_valid_d;
            clamp_hit_q      <= clamp_hit_d;
            ready_q          <= ready_d;
            done_q           <= done_d;
            overflow_q       <= overflow_d;
            avm_write_q      <= avm_write_d;
            avm_address_q    <= avm_address_d;
            avm_byteenable_q <= avm_byteenable_d;
            avm_writedata_q  <= avm_writedata_d;
        end
    end

    assign bus.ready_o          = ready_q;
    assign bus.done_o           = done_q;
    assign bus.overflow_o       = overflow_q;
    assign bus.avm_write_o      = avm_write_q;
    assign bus.avm_address_o    = avm_address_q;
    assign bus.avm_byteenable_o = avm_byteenable_q;
    assign bus.avm_writedata_o  = avm_writedata_q;
endmodule

// File: tb/tb_avalon_seg_writer_de1soc.sv
// Directed vector bench for the segment writer: per-cycle output snapshots
// against a hand-written write schedule.
module tb_avalon_seg_writer_de1soc;

    typedef struct {
        logic [19:0] value;
        int          stall_addr;
        int          stall_n;
        bit          hold_valid;
        bit          exp_ovf;
        logic [5:0]  exp_mask;
        logic [23:0] exp_bcd;
    } vec_t;

    // Snapshot layout: {write, address[2:0], byteenable[3:0], writedata[31:0], done, overflow, ready}
    localparam logic [42:0] RESET_SNAP = 43'h1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    avalon_seg_writer_de1soc_if #(.DATA_W(20)) bus ();

    avalon_seg_writer_de1soc #(.NUM_SEGMENT(6), .DATA_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [42:0] snap();
        return {bus.avm_write_o, bus.avm_address_o, bus.avm_byteenable_o,
                bus.avm_writedata_o, bus.done_o, bus.overflow_o, bus.ready_o};
    endfunction

    task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept v.value at edge T and compare every cycle up to the done pulse.
    // abort_k >= 0 asserts reset asynchronously in cycle T+abort_k.
    task automatic run_update(input int id, input vec_t v, input int abort_k);
        int          start_k[6];
        int          len_k[6];
        int          cyc, done_k, stalls;
        logic [42:0] exp_s;
        cyc = 21;
        for (int a = 0; a < 6; a++) begin
            start_k[a] = cyc;
            len_k[a]   = (v.exp_mask[a] && a == v.stall_addr) ? v.stall_n + 1 : 1;
            cyc       += len_k[a];
        end
        done_k = cyc;
        stalls = v.stall_n;
        bus.value_i = v.value;
        bus.valid_i = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= done_k; k++) begin
            @(negedge clk);
            if (!v.hold_valid) bus.valid_i = 1'b0;
            exp_s = '0;
            for (int a = 0; a < 6; a++) begin
                if (v.exp_mask[a] && k >= start_k[a] && k < start_k[a] + len_k[a])
                    exp_s[42:3] = {1'b1, 3'(a), 4'b0001, 28'b0, v.exp_bcd[4*a +: 4]};
            end
            exp_s[2] = (k == done_k);
            exp_s[1] = v.exp_ovf && (k == 1);
            exp_s[0] = (k == done_k);
            check($sformatf("vec%0d T+%0d", id, k), snap(), exp_s);
            bus.avm_waitrequest_i = 1'b0;
            if (bus.avm_write_o && int'(bus.avm_address_o) == v.stall_addr && stalls > 0) begin
                bus.avm_waitrequest_i = 1'b1;
                stalls--;
            end
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1 check($sformatf("vec%0d async_reset", id), snap(), RESET_SNAP);
                bus.avm_waitrequest_i = 1'b0;
                bus.valid_i = 1'b0;
                @(negedge clk);
                check($sformatf("vec%0d reset_hold", id), snap(), RESET_SNAP);
                rst_n = 1'b1;
                return;
            end
        end
        bus.valid_i           = 1'b0;
        bus.avm_waitrequest_i = 1'b0;
    endtask

    vec_t vecs[8];
    vec_t hv;

    initial begin
        vecs[0] = '{20'd123456,  -1, 0, 1'b0, 1'b0, 6'h3F, 24'h123456};
        vecs[1] = '{20'd123457,  -1, 0, 1'b0, 1'b0, 6'h01, 24'h123457};
        vecs[2] = '{20'd123457,  -1, 0, 1'b0, 1'b0, 6'h00, 24'h123457};
        vecs[3] = '{20'd1048575, -1, 0, 1'b1, 1'b1, 6'h3F, 24'h999999};
        vecs[4] = '{20'd0,       -1, 0, 1'b0, 1'b0, 6'h3F, 24'h000000};
        vecs[5] = '{20'd999999,  -1, 0, 1'b0, 1'b0, 6'h3F, 24'h999999};
        vecs[6] = '{20'd1000000, -1, 0, 1'b0, 1'b1, 6'h00, 24'h999999};
        vecs[7] = '{20'd999990,  -1, 0, 1'b0, 1'b0, 6'h01, 24'h999990};

        rst_n                 = 1'b0;
        bus.value_i           = '0;
        bus.valid_i           = 1'b0;
        bus.avm_waitrequest_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", snap(), RESET_SNAP);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_update(i, vecs[i], -1);

        // Reset while address 3 is on the bus, then a full rewrite with a stall on address 2.
        hv = '{20'd123456, -1, 0, 1'b0, 1'b0, 6'h3F, 24'h123456};
        run_update(8, hv, 24);
        hv = '{20'd123456, 2, 3, 1'b0, 1'b0, 6'h3F, 24'h123456};
        run_update(9, hv, -1);

        // An idle reset must also forget the shadow: all-zero digits are rewritten.
        hv = '{20'd0, -1, 0, 1'b0, 1'b0, 6'h3F, 24'h000000};
        run_update(10, hv, -1);
        rst_n = 1'b0;
        #1 check("idle_reset", snap(), RESET_SNAP);
        @(negedge clk);
        rst_n = 1'b1;
        run_update(11, hv, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_seg_writer_de1soc.md
# avalon_seg_writer_de1soc

Avalon-MM write initiator that drives the DE1-SoC seven-segment display slave. It accepts a binary value over a valid/ready handshake and converts it to BCD sequentially (double-dabble, one shift per cycle). It then writes each decimal digit to the per-digit display registers at word addresses 0..NUM_SEGMENT-1. Only digits that changed since the last completed update are written, which keeps bus traffic low when a counter or measurement is shown.

## Interface
- NUM_SEGMENT, 6: number of digits/slave words; legal range 1..8.
- DATA_W, 20: width of the binary input value.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- value_i  input  DATA_W  binary value to display.
- valid_i  input  1  value_i valid.
- ready_o  output  1  block idle and able to accept a value.
- done_o  output  1  one-cycle pulse when an update finishes.
- overflow_o  output  1  one-cycle pulse on accept if value_i was clamped.
- avm_address_o  output  3  word address (digit index).
- avm_byteenable_o  output  4  always 4'b0001 during a write.
- avm_write_o  output  1  write request.
- avm_writedata_o  output  32  {28'b0, BCD digit}.
- avm_waitrequest_i  input  1  slave stall.

## Operation
- FSM states: IDLE, CONVERT, WRITE.
- IDLE: ready_o=1. valid_i&&ready_o accepts the value and moves to CONVERT. If value_i > 10^NUM_SEGMENT-1, the value is clamped to 10^NUM_SEGMENT-1 and overflow_o pulses in the cycle after accept.
- CONVERT: exactly DATA_W cycles. Each cycle applies add-3 to every BCD nibble ≥5, then shifts the binary MSB into the BCD register (NUM_SEGMENT*4 bits). The counter width is $clog2(DATA_W+1).
- WRITE: digit index i runs 0..NUM_SEGMENT-1, one index per cycle minimum.
  - A write is issued when shadow_valid=0 or digit[i]≠shadow[i].
  - An unchanged digit consumes one cycle with avm_write_o=0.
- During a write, address, data and byteenable are held stable while avm_waitrequest_i=1. The write completes in the cycle where avm_write_o=1 and avm_waitrequest_i=0. On completion shadow[i] is updated and i advances.
- After index NUM_SEGMENT-1 completes: shadow_valid<=1, state→IDLE, done_o pulses.
- valid_i outside IDLE is ignored; no queueing.
- Reset values: state IDLE, ready_o=1, done_o=0, overflow_o=0, avm_write_o=0, avm_address_o=0, avm_byteenable_o=0, avm_writedata_o=0, shadow cleared, shadow_valid=0.
- Reset mid-operation (any state): all outputs return immediately to reset values and shadow_valid=0, so the next update writes all digits.
- avm_address_o, byteenable and writedata are 0 whenever avm_write_o=0.

## Timing
- Accept at edge T: CONVERT occupies cycles T+1..T+DATA_W. WRITE starts at T+DATA_W+1.
- With no stalls and all digits written, WRITE lasts NUM_SEGMENT cycles. done_o=1 and ready_o=1 occur together at T+DATA_W+NUM_SEGMENT+1; defaults give T+27.
- Each waitrequest cycle adds one cycle of latency.
- All outputs are registered. The only combinational path to an output is none; waitrequest is sampled at the edge.

## Structure
- Package seg_writer_pkg contains:
  - state_t enum {IDLE, CONVERT, WRITE};
  - bcd_digit_t (logic [3:0]);
  - function pow10_max(n) returning 10^n-1 for the clamp constant;
  - localparam BYTEEN_DIGIT = 4'b0001.
- Sub-module bin_to_bcd_seq holds the double-dabble shift/add-3 register and counter, with start/busy/done and parameters DATA_W and NUM_SEGMENT. The top module holds the FSM, the shadow registers and the Avalon master.

## Test plan
- Reset: assert rst_n=0 mid-cycle. All outputs go to their reset values asynchronously, and ready_o=1 after release.
- First update, value_i=123456, no stalls: six writes at addresses 0..5 with writedata 6,5,4,3,2,1 and byteenable 4'b0001 on consecutive cycles T+21..T+26. done_o pulses at T+27.
- Incremental update: after the above, value_i=123457 produces exactly one write, address 0 with data 7. done_o still pulses at T+27.
- Stall: in the first update, hold avm_waitrequest_i=1 for 3 cycles on address 2. Address 2 and data 4 stay stable for 4 cycles, and done_o moves to T+30.
- Clamp: value_i=1048575 gives overflow_o pulse at T+1 and digits 9,9,9,9,9,9. Assert valid_i continuously during busy: no extra accept, ready_o=0 until done.
- Reset during WRITE at address 3: avm_write_o drops immediately. The next value_i=123456 writes all six digits again.
